counter_100_checker: RTL and testbench

COUNTER_100_CHECKER -- requirements
Module: counter_100_checker

---
 rtl/counter_100_checker.sv | 183 ++++++++++++++++++
 tb/tb_counter_100_checker.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_100_checker.sv
// counter_100_checker: watches a modulo-MAX_CNT counter and confirms that
// every enabled sample is the successor of the previous one. It locks after
// two consecutive good samples and flags sequence breaks and out-of-range
// values. It also keeps a sticky error flag, a saturating error count and a
// count of confirmed wraps.
module counter_100_checker #(
  parameter int MAX_CNT = 100,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       i_cnt,
  input  logic             i_en,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_range_err,
  output logic             o_err_sticky,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [15:0]      o_wrap_cnt,
  output logic [6:0]       o_expected
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       MAX_V   = 8'(MAX_CNT);
  localparam logic [6:0]       LAST_V  = 7'(MAX_CNT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  // Value that must follow 'value' in a healthy modulo-MAX_CNT sequence.
  function automatic logic [6:0] successor(input logic [6:0] value);
    logic [6:0] result;
    if (value == LAST_V) begin
      result = 7'd0;
    end else begin
      result = value + 7'd1;
    end
    return result;
  endfunction

  state_t            state_r, state_s;
  logic [6:0]        ref_r, ref_s;
  logic              in_range_s;
  logic              match_s;
  logic              err_pulse_s;
  logic              range_pulse_s;
  logic              wrap_hit_s;
  logic              err_event_s;
  logic [ERR_W-1:0]  err_base_s;
  logic [15:0]       wrap_base_s;
  logic              sticky_base_s;
  logic [ERR_W-1:0]  err_cnt_s;
  logic [15:0]       wrap_cnt_s;
  logic              sticky_s;
  logic              locked_s;
  logic [6:0]        expected_s;

  logic              locked_r;
  logic              err_r;
  logic              range_err_r;
  logic              sticky_r;
  logic [ERR_W-1:0]  err_cnt_r;
  logic [15:0]       wrap_cnt_r;
  logic [6:0]        expected_r;

  assign in_range_s = ({1'b0, i_cnt} < MAX_V);
  assign match_s    = (i_cnt == successor(ref_r));

  // Next state and reference: range errors win over sequence checks in every state.
  always_comb begin
    state_s       = state_r;
    ref_s         = ref_r;
    err_pulse_s   = 1'b0;
    range_pulse_s = 1'b0;
    wrap_hit_s    = 1'b0;
    if (i_en) begin
      if (!in_range_s) begin
        range_pulse_s = 1'b1;
        state_s       = ST_IDLE;
        ref_s         = 7'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_s = ST_ACQ;
            ref_s   = i_cnt;
          end
          ST_ACQ: begin
            ref_s = i_cnt;
            if (match_s) begin
              state_s = ST_LOCKED;
            end else begin
              state_s = ST_ACQ;
            end
          end
          ST_LOCKED: begin
            ref_s = i_cnt;
            if (match_s) begin
              state_s    = ST_LOCKED;
              wrap_hit_s = (i_cnt == 7'd0) && (ref_r == LAST_V);
            end else begin
              state_s     = ST_ACQ;
              err_pulse_s = 1'b1;
            end
          end
          default: begin
            state_s = ST_IDLE;
            ref_s   = 7'd0;
          end
        endcase
      end
    end else begin
      state_s = state_r;
      ref_s   = ref_r;
    end
  end

  // Statistics: a clear is applied first so a same-cycle event lands on a zeroed counter.
  always_comb begin
    err_event_s   = err_pulse_s | range_pulse_s;
    err_base_s    = i_clear ? {ERR_W{1'b0}} : err_cnt_r;
    wrap_base_s   = i_clear ? 16'd0 : wrap_cnt_r;
    sticky_base_s = i_clear ? 1'b0 : sticky_r;
    if (err_event_s && (err_base_s != ERR_MAX)) begin
      err_cnt_s = err_base_s + ERR_ONE;
    end else begin
      err_cnt_s = err_base_s;
    end
    if (wrap_hit_s) begin
      wrap_cnt_s = wrap_base_s + 16'd1;
    end else begin
      wrap_cnt_s = wrap_base_s;
    end
    sticky_s   = sticky_base_s | err_event_s;
    locked_s   = (state_s == ST_LOCKED);
    expected_s = (state_s == ST_IDLE) ? 7'd0 : successor(ref_s);
  end

  // FSM state and reference register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      ref_r   <= 7'd0;
    end else begin
      state_r <= state_s;
      ref_r   <= ref_s;
    end
  end

  // Registered copies of every output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_r    <= 1'b0;
      err_r       <= 1'b0;
      range_err_r <= 1'b0;
      sticky_r    <= 1'b0;
      err_cnt_r   <= {ERR_W{1'b0}};
      wrap_cnt_r  <= 16'd0;
      expected_r  <= 7'd0;
    end else begin
      locked_r    <= locked_s;
      err_r       <= err_pulse_s;
      range_err_r <= range_pulse_s;
      sticky_r    <= sticky_s;
      err_cnt_r   <= err_cnt_s;
      wrap_cnt_r  <= wrap_cnt_s;
      expected_r  <= expected_s;
    end
  end

  assign o_locked     = locked_r;
  assign o_err        = err_r;
  assign o_range_err  = range_err_r;
  assign o_err_sticky = sticky_r;
  assign o_err_cnt    = err_cnt_r;
  assign o_wrap_cnt   = wrap_cnt_r;
  assign o_expected   = expected_r;

endmodule

// File: tb/tb_counter_100_checker.sv
// Testbench for counter_100_checker: a default instance and an ERR_W=2
// instance share stimulus; a behavioural model predicts every output.
module tb_counter_100_checker;
  localparam int MAX = 100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  i_cnt;
  logic        i_en;
  logic        i_clear;

  logic        o_locked, o_err, o_range_err, o_err_sticky;
  logic [7:0]  o_err_cnt;
  logic [15:0] o_wrap_cnt;
  logic [6:0]  o_expected;

  logic        d2_locked, d2_err, d2_range_err, d2_err_sticky;
  logic [1:0]  d2_err_cnt;
  logic [15:0] d2_wrap_cnt;
  logic [6:0]  d2_expected;

  counter_100_checker dut (
    .clk(clk), .reset_n(reset_n), .i_cnt(i_cnt), .i_en(i_en), .i_clear(i_clear),
    .o_locked(o_locked), .o_err(o_err), .o_range_err(o_range_err),
    .o_err_sticky(o_err_sticky), .o_err_cnt(o_err_cnt), .o_wrap_cnt(o_wrap_cnt),
    .o_expected(o_expected)
  );

  counter_100_checker #(.MAX_CNT(100), .ERR_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .i_cnt(i_cnt), .i_en(i_en), .i_clear(i_clear),
    .o_locked(d2_locked), .o_err(d2_err), .o_range_err(d2_range_err),
    .o_err_sticky(d2_err_sticky), .o_err_cnt(d2_err_cnt), .o_wrap_cnt(d2_wrap_cnt),
    .o_expected(d2_expected)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: m_run = number of consecutive good samples held (0, 1, 2+)
  int m_run, m_ref, m_err, m_err2, m_wrap;
  bit m_sticky, m_err_p, m_rng_p;

  task automatic model_reset();
    m_run = 0; m_ref = 0; m_err = 0; m_err2 = 0; m_wrap = 0;
    m_sticky = 1'b0; m_err_p = 1'b0; m_rng_p = 1'b0;
  endtask

  task automatic model_step(input bit en, input int cnt, input bit clr);
    m_err_p = 1'b0;
    m_rng_p = 1'b0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (clr) begin
      m_err = 0; m_err2 = 0; m_wrap = 0; m_sticky = 1'b0;
    end
    if (en) begin
      if (cnt >= MAX) begin
        m_rng_p = 1'b1;
        m_run   = 0;
      end else if (m_run == 0) begin
        m_run = 1;
        m_ref = cnt;
      end else if (cnt == (m_ref + 1) % MAX) begin
        if (m_run == 2 && cnt == 0) m_wrap = (m_wrap + 1) % 65536;
        m_run = 2;
        m_ref = cnt;
      end else begin
        if (m_run == 2) m_err_p = 1'b1;
        m_run = 1;
        m_ref = cnt;
      end
    end
    if (m_err_p || m_rng_p) begin
      m_sticky = 1'b1;
      if (m_err < 255) m_err++;
      if (m_err2 < 3) m_err2++;
    end
  endtask

  function automatic logic [63:0] model_vec();
    logic [6:0] e;
    logic       l;
    e = (m_run == 0) ? 7'd0 : 7'((m_ref + 1) % MAX);
    l = (m_run == 2);
    return {l, m_err_p, m_rng_p, m_sticky, 8'(m_err), 2'(m_err2), 16'(m_wrap), e,
            l, m_err_p, m_rng_p, m_sticky, 16'(m_wrap), e};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {o_locked, o_err, o_range_err, o_err_sticky, o_err_cnt, d2_err_cnt, o_wrap_cnt, o_expected,
            d2_locked, d2_err, d2_range_err, d2_err_sticky, d2_wrap_cnt, d2_expected};
  endfunction

  task automatic tick(input bit en, input int cnt, input bit clr);
    i_en = en; i_cnt = 7'(cnt); i_clear = clr;
    @(posedge clk);
    model_step(en, cnt, clr);
    #1;
  endtask

  task automatic apply_reset();
    i_en = 1'b0; i_clear = 1'b0; i_cnt = 7'd0;
    reset_n = 1'b0;
    model_reset();
    #10;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_en = 1'b1; i_cnt = 7'd5; i_clear = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 64'd0) $display("FAIL reset_initial: got %h expected 0", dut_vec());
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 5 + k, 1'b0);
      n_checks++;
      if (dut_vec() !== 64'd0) $display("FAIL reset_held_en[%0d]: got %h expected 0", k, dut_vec());
      else n_pass++;
    end
    reset_n = 1'b1;
    tick(1'b0, 0, 1'b0);
    n_checks++;
    if (dut_vec() !== model_vec()) $display("FAIL reset_release: got %h expected %h", dut_vec(), model_vec());
    else n_pass++;
  endtask

  task automatic test_count_sequence();
    apply_reset();
    for (int v = 0; v <= 20; v++) begin
      tick(1'b1, v, 1'b0);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL seq_vec[%0d]: got %h expected %h", v, dut_vec(), model_vec());
      else n_pass++;
      n_checks++;
      if (o_locked !== (v >= 1) || o_err !== 1'b0 || o_expected !== 7'(v + 1))
        $display("FAIL seq_lock[%0d]: got locked=%b err=%b exp=%0d required locked=%b err=0 exp=%0d",
                 v, o_locked, o_err, o_expected, (v >= 1), v + 1);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i <= 200; i++) begin
      tick(1'b1, i % MAX, 1'b0);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL wrap_vec[%0d]: got %h expected %h", i, dut_vec(), model_vec());
      else n_pass++;
    end
    n_checks++;
    if (o_wrap_cnt !== 16'd2 || o_err_cnt !== 8'd0)
      $display("FAIL wrap_total: got wrap=%0d errs=%0d required wrap=2 errs=0", o_wrap_cnt, o_err_cnt);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    int vals[6] = '{38, 39, 40, 45, 46, 47};
    apply_reset();
    foreach (vals[i]) begin
      tick(1'b1, vals[i], 1'b0);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL mismatch_vec[%0d]: got %h expected %h", i, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_mismatch_detail();
    apply_reset();
    tick(1'b1, 39, 1'b0);
    tick(1'b1, 40, 1'b0);
    tick(1'b1, 45, 1'b0);
    n_checks++;
    if (o_err !== 1'b1 || o_err_cnt !== 8'd1 || o_locked !== 1'b0)
      $display("FAIL mismatch_45: got err=%b cnt=%0d locked=%b required 1 1 0", o_err, o_err_cnt, o_locked);
    else n_pass++;
    tick(1'b1, 46, 1'b0);
    n_checks++;
    if (o_err !== 1'b0 || o_locked !== 1'b1)
      $display("FAIL relock_46: got err=%b locked=%b required 0 1", o_err, o_locked);
    else n_pass++;
  endtask

  task automatic test_range();
    apply_reset();
    tick(1'b1, 20, 1'b0);
    tick(1'b1, 21, 1'b0);
    tick(1'b1, 100, 1'b0);
    n_checks++;
    if (o_range_err !== 1'b1 || o_err !== 1'b0 || o_expected !== 7'd0 || o_err_sticky !== 1'b1 || o_locked !== 1'b0)
      $display("FAIL range_100: got rng=%b err=%b exp=%0d sticky=%b locked=%b required 1 0 0 1 0",
               o_range_err, o_err, o_expected, o_err_sticky, o_locked);
    else n_pass++;
    tick(1'b1, 127, 1'b0);
    n_checks++;
    if (dut_vec() !== model_vec()) $display("FAIL range_127: got %h expected %h", dut_vec(), model_vec());
    else n_pass++;
    tick(1'b1, 0, 1'b0);
    n_checks++;
    if (dut_vec() !== model_vec()) $display("FAIL range_recover: got %h expected %h", dut_vec(), model_vec());
    else n_pass++;
  endtask

  task automatic test_stall();
    apply_reset();
    tick(1'b1, 8, 1'b0);
    tick(1'b1, 9, 1'b0);
    tick(1'b1, 10, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 77, 1'b0);
      n_checks++;
      if (o_err !== 1'b0 || o_range_err !== 1'b0 || o_locked !== 1'b1 || o_expected !== 7'd11)
        $display("FAIL stall[%0d]: got err=%b rng=%b locked=%b exp=%0d required 0 0 1 11",
                 k, o_err, o_range_err, o_locked, o_expected);
      else n_pass++;
    end
    tick(1'b1, 11, 1'b0);
    n_checks++;
    if (o_err !== 1'b0 || o_locked !== 1'b1 || o_err_cnt !== 8'd0)
      $display("FAIL stall_resume: got err=%b locked=%b cnt=%0d required 0 1 0", o_err, o_locked, o_err_cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    apply_reset();
    tick(1'b1, 0, 1'b0);
    tick(1'b1, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 50 + 10 * k, 1'b0);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL sat_mis[%0d]: got %h expected %h", k, dut_vec(), model_vec());
      else n_pass++;
      tick(1'b1, 51 + 10 * k, 1'b0);
    end
    n_checks++;
    if (d2_err_cnt !== 2'd3 || o_err_cnt !== 8'd5)
      $display("FAIL sat_five: got w2=%0d w8=%0d required 3 5", d2_err_cnt, o_err_cnt);
    else n_pass++;
    tick(1'b1, 90, 1'b1);
    n_checks++;
    if (d2_err_cnt !== 2'd1 || o_err_cnt !== 8'd1 || o_err !== 1'b1 || d2_err_sticky !== 1'b1)
      $display("FAIL sat_clear_err: got w2=%0d w8=%0d err=%b sticky=%b required 1 1 1 1",
               d2_err_cnt, o_err_cnt, o_err, d2_err_sticky);
    else n_pass++;
    for (int k = 0; k < 260; k++) begin
      tick(1'b1, 100 + (k % 28), 1'b0);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL sat_rng[%0d]: got %h expected %h", k, dut_vec(), model_vec());
      else n_pass++;
    end
    n_checks++;
    if (o_err_cnt !== 8'hff || d2_err_cnt !== 2'd3 || o_range_err !== 1'b1 || o_err_sticky !== 1'b1)
      $display("FAIL sat_hold: got w8=%0d w2=%0d rng=%b sticky=%b required 255 3 1 1",
               o_err_cnt, d2_err_cnt, o_range_err, o_err_sticky);
    else n_pass++;
  endtask

  task automatic test_clear();
    apply_reset();
    tick(1'b1, 98, 1'b0);
    tick(1'b1, 99, 1'b0);
    tick(1'b1, 0, 1'b1);
    n_checks++;
    if (o_wrap_cnt !== 16'd1 || o_locked !== 1'b1)
      $display("FAIL clear_wrap: got wrap=%0d locked=%b required 1 1", o_wrap_cnt, o_locked);
    else n_pass++;
    tick(1'b1, 1, 1'b0);
    tick(1'b1, 5, 1'b0);
    tick(1'b1, 6, 1'b0);
    tick(1'b0, 33, 1'b1);
    n_checks++;
    if (o_locked !== 1'b1 || o_expected !== 7'd7 || o_err_cnt !== 8'd0 || o_err_sticky !== 1'b0 || o_wrap_cnt !== 16'd0)
      $display("FAIL clear_only: got locked=%b exp=%0d cnt=%0d sticky=%b wrap=%0d required 1 7 0 0 0",
               o_locked, o_expected, o_err_cnt, o_err_sticky, o_wrap_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midseq();
    apply_reset();
    tick(1'b1, 30, 1'b0);
    tick(1'b1, 31, 1'b0);
    tick(1'b1, 32, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== 64'd0) $display("FAIL midseq_async: got %h expected 0", dut_vec());
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 33 + k, 1'b0);
      n_checks++;
      if (dut_vec() !== 64'd0) $display("FAIL midseq_held[%0d]: got %h expected 0", k, dut_vec());
      else n_pass++;
    end
    reset_n = 1'b1;
    tick(1'b1, 35, 1'b0);
    n_checks++;
    if (o_locked !== 1'b0 || o_expected !== 7'd36)
      $display("FAIL midseq_acq: got locked=%b exp=%0d required 0 36", o_locked, o_expected);
    else n_pass++;
    tick(1'b1, 36, 1'b0);
    n_checks++;
    if (o_locked !== 1'b1) $display("FAIL midseq_relock: got locked=%b required 1", o_locked);
    else n_pass++;
  endtask

  task automatic test_random();
    int c;
    int cnt;
    int r;
    bit en;
    bit clr;
    apply_reset();
    c = 0;
    for (int k = 0; k < 4000; k++) begin
      en  = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 99) < 3);
      r   = $urandom_range(0, 99);
      if (r < 80)      cnt = (c + 1) % MAX;
      else if (r < 88) cnt = $urandom_range(0, MAX - 1);
      else if (r < 93) cnt = c;
      else             cnt = MAX + $urandom_range(0, 27);
      if (en && cnt < MAX) c = cnt;
      tick(en, cnt, clr);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL random[%0d]: got %h expected %h", k, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    reset_n = 1'b0; i_en = 1'b0; i_cnt = 7'd0; i_clear = 1'b0;
    model_reset();
    test_reset();
    test_count_sequence();
    test_wrap();
    test_mismatch();
    test_mismatch_detail();
    test_range();
    test_stall();
    test_saturation();
    test_clear();
    test_reset_midseq();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
